instr_encoder: RTL and testbench



---
 rtl/instr_pkg.sv | 20 ++
 rtl/imm_pack.sv | 27 ++
 rtl/instr_encoder.sv | 132 +++++++++++++
 tb/tb_instr_encoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared types and constants for the instruction encoder/loader: field formats,
// common opcodes and the load FSM state encoding.
package instr_pkg;

  typedef enum logic {
    FMT_I = 1'b0,
    FMT_B = 1'b1
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: turns decoded fields into a 32-bit I-type or B-type word
// whose immediate bits land where the core's immediate decoder expects them.
module imm_pack
  import instr_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [11:0] imm_i,
  output logic [31:0] word_o
);

  // B-type carries a halfword-scaled offset, so imm[10] sits at bit 7.
  always_comb begin
    word_o = 32'h0000_0000;
    case (fmt_i)
      FMT_I:   word_o = {imm_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_B:   word_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                         imm_i[3:0], imm_i[10], opcode_i};
      default: word_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder and program loader writing packed words to
// consecutive instruction-memory addresses. Option: INSTR_ENCODER_IMM_RANGE_CHK_EN.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [LEN_WIDTH-1:0]   length,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_fmt,
  input  logic [6:0]             in_opcode,
  input  logic [4:0]             in_rd,
  input  logic [2:0]             in_funct3,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [DATA_WIDTH-1:0]  in_imm,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic [LEN_WIDTH-1:0]   count,
  output logic                   err
);

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   remaining_q;
  logic [LEN_WIDTH-1:0]   count_q;
  logic                   wr_en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [INSTR_WIDTH-1:0] wr_data_q;
  logic [INSTR_WIDTH-1:0] word_d;
  logic                   accept_s;
  logic                   imm_ok_s;

  assign in_ready = (state_q == S_LOAD) && (remaining_q != '0);
  assign accept_s = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign count    = count_q;

  imm_pack u_imm_pack (
    .fmt_i    (fmt_e'(in_fmt)),
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .funct3_i (in_funct3),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .imm_i    (in_imm[11:0]),
    .word_o   (word_d)
  );

`ifdef INSTR_ENCODER_IMM_RANGE_CHK_EN
  logic err_q;

  // In range only when everything from bit 11 up is a pure sign extension.
  assign imm_ok_s = (&in_imm[DATA_WIDTH-1:11]) || (~|in_imm[DATA_WIDTH-1:11]);
  assign err      = err_q;

  // Sticky range error, cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      err_q <= 1'b0;
    end else if (accept_s && !imm_ok_s) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_imm_s;

  assign imm_ok_s     = 1'b1;
  assign err          = 1'b0;
  assign unused_imm_s = ^in_imm[DATA_WIDTH-1:12];
`endif

  // Load FSM with its registered write port, address and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q      <= base_addr;
            remaining_q <= length;
            count_q     <= '0;
            state_q     <= (length == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept_s) begin
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            if (imm_ok_s) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= word_d;
              addr_q    <= addr_q + ADDR_WIDTH'(1);
              count_q   <= count_q + LEN_WIDTH'(1);
            end
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;
  import instr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic [7:0]  length = 8'h00;
  logic        busy, done, in_ready, wr_en, err;
  logic        in_valid = 1'b0;
  logic        in_fmt = 1'b0;
  logic [6:0]  in_opcode = 7'h00;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_imm = 32'h0;
  logic [7:0]  wr_addr, count;
  logic [31:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input logic fmt, input logic [6:0] opc, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_opcode = opc;
    in_rd     = rd;
    in_funct3 = f3;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic do_start(input logic [7:0] base, input logic [7:0] len);
    start     = 1'b1;
    base_addr = base;
    length    = len;
    tick();
    start     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_busy"},     busy,     32'd0);
    check_eq({pfx, "_done"},     done,     32'd0);
    check_eq({pfx, "_in_ready"}, in_ready, 32'd0);
    check_eq({pfx, "_wr_en"},    wr_en,    32'd0);
    check_eq({pfx, "_wr_addr"},  wr_addr,  32'd0);
    check_eq({pfx, "_wr_data"},  wr_data,  32'd0);
    check_eq({pfx, "_count"},    count,    32'd0);
    check_eq({pfx, "_err"},      err,      32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] dec;
    logic [7:0]  wrap_addr [4];
    logic [31:0] wrap_data [4];
    wrap_addr = '{8'd254, 8'd255, 8'd0, 8'd1};
    wrap_data = '{32'h0000_0093, 32'h0010_0113, 32'h0020_0193, 32'h0030_0213};

    #12;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // I-type ADDI x5, x0, -1
    do_start(8'h10, 8'd1);
    check_eq("i_busy", busy, 32'd1);
    check_eq("i_ready", in_ready, 32'd1);
    check_eq("i_done_early", done, 32'd0);
    set_entry(1'b0, OP_IMM, 5'd5, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
    tick();
    in_valid = 1'b0;
    check_eq("i_wr_en", wr_en, 32'd1);
    check_eq("i_wr_addr", wr_addr, 32'h10);
    check_eq("i_wr_data", wr_data, 32'hFFF0_0293);
    check_eq("i_done", done, 32'd1);
    check_eq("i_busy_done", busy, 32'd1);
    check_eq("i_count", count, 32'd1);
    check_eq("i_ready_done", in_ready, 32'd0);
    tick();
    check_eq("i_busy_idle", busy, 32'd0);
    check_eq("i_done_idle", done, 32'd0);
    check_eq("i_wr_en_idle", wr_en, 32'd0);

    // B-type round trip, imm 0x7FF
    do_start(8'h20, 8'd1);
    set_entry(1'b1, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 32'h0000_07FF);
    tick();
    in_valid = 1'b0;
    check_eq("b_wr_en", wr_en, 32'd1);
    check_eq("b_wr_addr", wr_addr, 32'h20);
    check_eq("b_wr_data", wr_data, 32'h7E20_8FE3);
    w   = wr_data;
    dec = {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
    check_eq("b_decode", dec, 32'h0000_07FF);
    tick();

    // Back-to-back with address wrap
    do_start(8'd254, 8'd4);
    for (int i = 0; i < 4; i++) begin
      set_entry(1'b0, OP_IMM, 5'(i + 1), 3'd0, 5'd0, 5'd0, 32'(i));
      tick();
      check_eq($sformatf("wrap_wr_en_%0d", i), wr_en, 32'd1);
      check_eq($sformatf("wrap_addr_%0d", i), wr_addr, 32'(wrap_addr[i]));
      check_eq($sformatf("wrap_data_%0d", i), wr_data, wrap_data[i]);
      check_eq($sformatf("wrap_count_%0d", i), count, 32'(i + 1));
      check_eq($sformatf("wrap_done_%0d", i), done, (i == 3) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    tick();
    check_eq("wrap_busy_end", busy, 32'd0);
    check_eq("wrap_count_end", count, 32'd4);

    // Zero-length load
    do_start(8'h40, 8'd0);
    check_eq("z_done", done, 32'd1);
    check_eq("z_wr_en", wr_en, 32'd0);
    check_eq("z_ready", in_ready, 32'd0);
    check_eq("z_count", count, 32'd0);
    tick();
    check_eq("z_done_clr", done, 32'd0);
    check_eq("z_busy", busy, 32'd0);
    check_eq("z_wr_en2", wr_en, 32'd0);

    // Start ignored during LOAD, gaps in in_valid
    do_start(8'h50, 8'd2);
    start = 1'b1; base_addr = 8'h90; length = 8'd7;
    tick();
    start = 1'b0;
    check_eq("g_wr_en_gap0", wr_en, 32'd0);
    check_eq("g_count_gap0", count, 32'd0);
    check_eq("g_ready", in_ready, 32'd1);
    set_entry(1'b0, OP_IMM, 5'd6, 3'd0, 5'd0, 5'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    check_eq("g_wr_en_a", wr_en, 32'd1);
    check_eq("g_addr_a", wr_addr, 32'h50);
    check_eq("g_data_a", wr_data, 32'h0050_0313);
    tick();
    check_eq("g_wr_en_gap1", wr_en, 32'd0);
    check_eq("g_count_gap1", count, 32'd1);
    start = 1'b1; base_addr = 8'hA0; length = 8'd9;
    set_entry(1'b0, OP_IMM, 5'd8, 3'd0, 5'd0, 5'd0, 32'd7);
    tick();
    start = 1'b0; in_valid = 1'b0;
    check_eq("g_addr_b", wr_addr, 32'h51);
    check_eq("g_data_b", wr_data, 32'h0070_0413);
    check_eq("g_count_b", count, 32'd2);
    check_eq("g_done", done, 32'd1);
    tick();
    check_eq("g_busy_end", busy, 32'd0);

    // Reset in the middle of a 5-entry load
    do_start(8'h60, 8'd5);
    set_entry(1'b0, OP_LOAD, 5'd1, 3'd2, 5'd2, 5'd0, 32'd4);
    tick();
    tick();
    check_eq("r_addr_2nd", wr_addr, 32'h61);
    check_eq("r_count_2nd", count, 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("r_mid");
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("r_no_done", done, 32'd0);
    check_eq("r_no_busy", busy, 32'd0);
    do_start(8'h70, 8'd1);
    set_entry(1'b0, OP_LOAD, 5'd3, 3'd2, 5'd4, 5'd0, 32'd8);
    tick();
    in_valid = 1'b0;
    check_eq("r_new_addr", wr_addr, 32'h70);
    check_eq("r_new_data", wr_data, 32'h0082_2183);
    check_eq("r_new_done", done, 32'd1);
    check_eq("r_new_count", count, 32'd1);
    tick();

`ifdef INSTR_ENCODER_IMM_RANGE_CHK_EN
    // Out-of-range middle entry is dropped and flagged
    do_start(8'h80, 8'd3);
    set_entry(1'b0, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 32'd1);
    tick();
    check_eq("c_wr_en0", wr_en, 32'd1);
    check_eq("c_addr0", wr_addr, 32'h80);
    set_entry(1'b0, OP_IMM, 5'd2, 3'd0, 5'd0, 5'd0, 32'h0000_0800);
    tick();
    check_eq("c_wr_en1", wr_en, 32'd0);
    check_eq("c_err1", err, 32'd1);
    check_eq("c_count1", count, 32'd1);
    set_entry(1'b0, OP_IMM, 5'd3, 3'd0, 5'd0, 5'd0, 32'd2);
    tick();
    in_valid = 1'b0;
    check_eq("c_wr_en2", wr_en, 32'd1);
    check_eq("c_addr2", wr_addr, 32'h81);
    check_eq("c_data2", wr_data, 32'h0020_0193);
    check_eq("c_count2", count, 32'd2);
    check_eq("c_done", done, 32'd1);
    check_eq("c_err2", err, 32'd1);
    tick();
    check_eq("c_err_hold", err, 32'd1);
    do_start(8'h00, 8'd0);
    check_eq("c_err_clr", err, 32'd0);
    tick();
`else
    // Without range checking the immediate is truncated to 12 bits
    do_start(8'h80, 8'd1);
    set_entry(1'b0, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0000_0800);
    tick();
    in_valid = 1'b0;
    check_eq("t_wr_en", wr_en, 32'd1);
    check_eq("t_data", wr_data, 32'h8000_0093);
    check_eq("t_err", err, 32'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
